// File: rtl/systolic_array_nxm.sv
// systolic_array_nxm: output-stationary ROWS x COLS systolic matrix multiplier.
// A columns stream in from the left, B rows stream in from the top.
// Each PE(i,j) accumulates a*b into acc(i,j). The result rows are then drained one per handshake.
// Optional feature macro: SYSTOLIC_SATURATE_EN. When it is defined, the accumulators saturate.
// When it is not defined, the accumulators wrap modulo 2^ACC_W.
//
// Handshakes (strict valid/ready): a beat or result row transfers on a rising edge
// where valid && ready are both high. The producer holds its data stable while
// valid && !ready. a_ready and res_valid depend only on the FSM state.
module systolic_array_nxm #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int K_W    = 8
) (
  input  logic                    CLOCK,
  input  logic                    reset,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ROWS*DATA_W-1:0]  a_col,
  input  logic [COLS*DATA_W-1:0]  b_row,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [COLS*ACC_W-1:0]   res_data,
  output logic                    res_last,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic [K_W-1:0]  beat_q, beat_d;
  logic [6:0]      flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;

  logic adv;
  logic clr;

  logic [ROWS-1:0][DATA_W-1:0]            a_in;
  logic [COLS-1:0][DATA_W-1:0]            b_in;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  a_tap;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  b_tap;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   acc_q, acc_d;

  logic signed [ACC_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]        sum;
`ifdef SYSTOLIC_SATURATE_EN
  logic [ACC_W:0]          sum_w;
`endif

  // The array moves on an accepted beat or on a FLUSH cycle. A start clears the array.
  assign adv = (state_q == LOAD && a_valid) || (state_q == FLUSH);
  assign clr = (state_q == IDLE) && start;

  // FLUSH pushes zero operands, so the operands already in flight finish without any new data added.
  assign a_in = (state_q == LOAD) ? a_col : '0;
  assign b_in = (state_q == LOAD) ? b_row : '0;

  assign busy      = (state_q != IDLE);
  assign a_ready   = (state_q == LOAD);
  assign res_valid = (state_q == DRAIN);
  assign res_last  = (state_q == DRAIN) && (row_q == RW'(ROWS - 1));
  assign res_data  = (state_q == DRAIN) ? acc_q[row_q] : '0;
  assign dbg_state = state_q;

  // Next-state logic for the control FSM and its beat/flush/row counters.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (a_valid) begin
          if (beat_q == k_q - K_W'(1)) begin
            beat_d  = '0;
            state_d = (FLUSH_N == 0) ? DRAIN : FLUSH;
          end else begin
            beat_d = beat_q + K_W'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_q == 7'(FLUSH_N - 1)) begin
          flush_d = '0;
          state_d = DRAIN;
        end else begin
          flush_d = flush_q + 7'd1;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
    end
  end

  // A path of row i: the i-cycle input skew and the rightward PE registers are merged into one shift chain.
  // PE(i,j) reads the operand delayed by i+j advances.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_arow
    localparam int LEN = gi + COLS - 1;
    if (LEN == 0) begin : g_none
      assign a_tap[gi][0] = a_in[gi];
    end else begin : g_chain
      logic [LEN-1:0][DATA_W-1:0] sr_q, sr_d;
      // Shift the row chain on each advance.
      always_comb begin
        sr_d = sr_q;
        if (clr) begin
          sr_d = '0;
        end else if (adv) begin
          sr_d[0] = a_in[gi];
          for (int m = 1; m < LEN; m++) sr_d[m] = sr_q[m-1];
        end
      end
      // Row chain registers.
      always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
      end
      for (genvar gj = 0; gj < COLS; gj++) begin : g_tap
        if (gi + gj == 0) begin : g_direct
          assign a_tap[gi][gj] = a_in[gi];
        end else begin : g_reg
          assign a_tap[gi][gj] = sr_q[gi+gj-1];
        end
      end
    end
  end

  // B path of column j: the j-cycle skew and the downward PE registers form one shift chain.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_bcol
    localparam int LEN = gj + ROWS - 1;
    if (LEN == 0) begin : g_none
      assign b_tap[0][gj] = b_in[gj];
    end else begin : g_chain
      logic [LEN-1:0][DATA_W-1:0] sr_q, sr_d;
      // Shift the column chain on each advance.
      always_comb begin
        sr_d = sr_q;
        if (clr) begin
          sr_d = '0;
        end else if (adv) begin
          sr_d[0] = b_in[gj];
          for (int m = 1; m < LEN; m++) sr_d[m] = sr_q[m-1];
        end
      end
      // Column chain registers.
      always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
      end
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_tap
        if (gi + gj == 0) begin : g_direct
          assign b_tap[gi][gj] = b_in[gj];
        end else begin : g_reg
          assign b_tap[gi][gj] = sr_q[gi+gj-1];
        end
      end
    end
  end

  // Multiply-accumulate for every PE. The product is sign-extended to ACC_W before the add.
  always_comb begin
    acc_d = acc_q;
    a_ext = '0;
    b_ext = '0;
    prod  = '0;
    sum   = '0;
`ifdef SYSTOLIC_SATURATE_EN
    sum_w = '0;
`endif
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        a_ext = ACC_W'($signed(a_tap[i][j]));
        b_ext = ACC_W'($signed(b_tap[i][j]));
        prod  = a_ext * b_ext;
`ifdef SYSTOLIC_SATURATE_EN
        sum_w = {acc_q[i][j][ACC_W-1], acc_q[i][j]} + {prod[ACC_W-1], prod};
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
          sum = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          sum = sum_w[ACC_W-1:0];
        end
`else
        sum = acc_q[i][j] + prod;
`endif
        if (clr)      acc_d[i][j] = '0;
        else if (adv) acc_d[i][j] = sum;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: tb/tb_systolic_array_nxm.sv
// tb_systolic_array_nxm: directed bench for systolic_array_nxm.
// u_dut uses the default 4x4 configuration. u_dut2 is 2x3 with ACC_W=16.
// The expected value in the narrow-accumulator case follows SYSTOLIC_SATURATE_EN.
module tb_systolic_array_nxm;

  // ---------------- clock / reset ----------------
  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;
  logic reset;

  // 4x4 instance signals
  logic        start, a_valid, res_ready;
  logic [7:0]  k_len;
  logic [31:0] a_col, b_row;
  logic        busy, a_ready, res_valid, res_last;
  logic [95:0] res_data;
  logic [1:0]  dbg_state;

  // 2x3 instance signals
  logic        start2, a_valid2, res_ready2;
  logic [7:0]  k_len2;
  logic [15:0] a_col2;
  logic [23:0] b_row2;
  logic        busy2, a_ready2, res_valid2, res_last2;
  logic [47:0] res_data2;
  logic [1:0]  dbg_state2;

  systolic_array_nxm u_dut (
    .CLOCK(CLOCK), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_col(a_col), .b_row(b_row),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .dbg_state(dbg_state)
  );

  systolic_array_nxm #(.ROWS(2), .COLS(3), .DATA_W(8), .ACC_W(16), .K_W(8)) u_dut2 (
    .CLOCK(CLOCK), .reset(reset), .start(start2), .k_len(k_len2), .busy(busy2),
    .a_valid(a_valid2), .a_ready(a_ready2), .a_col(a_col2), .b_row(b_row2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
    .res_last(res_last2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int failed = 0;
  int total  = 0;
  int am[4][8];
  int bm[8][4];
  int cm[4][4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compute_model(input int k);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += am[i][kk] * bm[kk][j];
        cm[i][j] = s;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. start is high for the next rising edge only.
  task automatic start_op(input int k);
    start = 1'b1;
    k_len = 8'(k);
    @(negedge CLOCK);
    start = 1'b0;
  endtask

  task automatic feed(input int k, input bit toggle);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < k && cyc < 200) begin
      a_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      for (int i = 0; i < 4; i++) a_col[i*8 +: 8] = am[i][idx][7:0];
      for (int j = 0; j < 4; j++) b_row[j*8 +: 8] = bm[idx][j][7:0];
      if (a_valid && a_ready) idx++;
      cyc++;
      @(negedge CLOCK);
    end
    a_valid = 1'b0;
    check("feed_beats", idx, k);
  endtask

  // Collects four rows and checks them against cm. Row stall_row is held off for stall_n cycles.
  // While that row is held off, start is kept asserted.
  task automatic drain(input string tag, input int stall_row, input int stall_n, input int exp_cycles);
    int wait_n;
    int cyc;
    logic [95:0] exp_row;
    wait_n = 0;
    cyc = 0;
    res_ready = 1'b1;
    while (!res_valid && wait_n < 200) begin
      @(negedge CLOCK);
      wait_n++;
    end
    check($sformatf("%s_valid", tag), res_valid, 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) exp_row[j*24 +: 24] = cm[r][j][23:0];
      for (int j = 0; j < 4; j++)
        check($sformatf("%s_r%0d_c%0d", tag, r, j), res_data[j*24 +: 24], exp_row[j*24 +: 24]);
      check($sformatf("%s_last_r%0d", tag, r), res_last, (r == 3));
      if (r == stall_row) begin
        res_ready = 1'b0;
        start = 1'b1;
        k_len = 8'd0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge CLOCK);
          cyc++;
          check($sformatf("%s_hold_%0d", tag, s), res_data, exp_row);
          check($sformatf("%s_hold_valid_%0d", tag, s), res_valid, 1'b1);
        end
        start = 1'b0;
        res_ready = 1'b1;
      end
      @(negedge CLOCK);
      cyc++;
    end
    check($sformatf("%s_idle", tag), busy, 1'b0);
    if (exp_cycles > 0) check($sformatf("%s_drain_cycles", tag), cyc, exp_cycles);
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 8; k++) am[i][k] = 0;
    for (int k = 0; k < 8; k++) for (int j = 0; j < 4; j++) bm[k][j] = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int vcount;
    int wait_n;
    logic [15:0] exp2;
    reset = 1'b1;
    start = 0; a_valid = 0; res_ready = 1; k_len = 0; a_col = 0; b_row = 0;
    start2 = 0; a_valid2 = 0; res_ready2 = 1; k_len2 = 0; a_col2 = 0; b_row2 = 0;
    repeat (3) @(negedge CLOCK);

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_last", res_last, 1'b0);
    check("rst_res_data", res_data, 96'd0);
    check("rst_state", dbg_state, 2'd0);
    check("rst2_res_valid", res_valid2, 1'b0);
    check("rst2_res_data", res_data2, 48'd0);
    reset = 1'b0;
    @(negedge CLOCK);

    // Identity A times B[k][j]=k*4+j
    clear_mats();
    for (int i = 0; i < 4; i++) am[i][i] = 1;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) bm[k][j] = k * 4 + j;
    compute_model(4);
    start_op(4);
    check("ident_busy", busy, 1'b1);
    check("ident_a_ready", a_ready, 1'b1);
    feed(4, 1'b0);
    drain("ident", -1, 0, 4);

    // Back-to-back: all -128, K=3 -> 49152. Start is issued in the first idle cycle.
    clear_mats();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 3; k++) am[i][k] = -128;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 4; j++) bm[k][j] = -128;
    compute_model(3);
    check("neg_model_sanity", cm[2][1][23:0], 24'd49152);
    start_op(3);
    check("b2b_busy", busy, 1'b1);
    feed(3, 1'b0);
    drain("neg", -1, 0, 4);

    // Mixed signs, K=2, a_valid toggling, row 1 stalled for 5 cycles with start held high
    clear_mats();
    am[0][0] = 1;  am[0][1] = 2;
    am[1][0] = -3; am[1][1] = 4;
    am[2][0] = 5;  am[2][1] = -6;
    am[3][0] = 7;  am[3][1] = 8;
    bm[0][0] = 1; bm[0][1] = -1; bm[0][2] = 2;  bm[0][3] = 0;
    bm[1][0] = 3; bm[1][1] = 1;  bm[1][2] = -2; bm[1][3] = 5;
    compute_model(2);
    start_op(2);
    feed(2, 1'b1);
    drain("stall", 1, 5, 0);

    // k_len = 0 -> four zero rows, no operand phase
    clear_mats();
    compute_model(0);
    start_op(0);
    check("kzero_a_ready", a_ready, 1'b0);
    check("kzero_state", dbg_state, 2'd3);
    drain("kzero", -1, 0, 4);

    // Reset during FLUSH aborts the operation
    clear_mats();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) am[i][k] = 3;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) bm[k][j] = 2;
    @(negedge CLOCK);
    start_op(4);
    feed(4, 1'b0);
    check("flush_busy", busy, 1'b1);
    check("flush_a_ready", a_ready, 1'b0);
    check("flush_state", dbg_state, 2'd2);
    reset = 1'b1;
    @(negedge CLOCK);
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_res_valid", res_valid, 1'b0);
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK);
      if (res_valid) vcount++;
    end
    check("abort_no_rows", vcount, 0);

    // K=1, A=B=1 after the abort -> all ones
    clear_mats();
    for (int i = 0; i < 4; i++) am[i][0] = 1;
    for (int j = 0; j < 4; j++) bm[0][j] = 1;
    compute_model(1);
    start_op(1);
    feed(1, 1'b0);
    drain("post_reset", -1, 0, 4);

    // 2x3 with ACC_W=16, K=4, A=B=127: 64516 wraps or saturates
`ifdef SYSTOLIC_SATURATE_EN
    exp2 = 16'h7FFF;
`else
    exp2 = 16'hFC04;
`endif
    a_col2 = {8'd127, 8'd127};
    b_row2 = {8'd127, 8'd127, 8'd127};
    a_valid2 = 1'b1;
    start2 = 1'b1;
    k_len2 = 8'd4;
    @(negedge CLOCK);
    start2 = 1'b0;
    wait_n = 0;
    while (!res_valid2 && wait_n < 200) begin
      @(negedge CLOCK);
      wait_n++;
    end
    check("narrow_valid", res_valid2, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++)
        check($sformatf("narrow_r%0d_c%0d", r, j), res_data2[j*16 +: 16], exp2);
      check($sformatf("narrow_last_r%0d", r), res_last2, (r == 1));
      @(negedge CLOCK);
    end
    a_valid2 = 1'b0;
    check("narrow_idle", busy2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
